multi_derived_clock: RTL and testbench

- Multi-channel programmable clock/strobe generator driven from the fabric clock.
- A shared prescaler produces a tick. Each channel runs its own tick counter with programmable period, high time and phase, so one block provides several phase-related derived clocks.
- Per-channel rise/fall strobes let downstream logic stay on `clk` and avoid routing derived clocks.
- Configuration changes are glitch-free: they take effect only at period boundaries, or on enable/sync.

---
 rtl/multi_derived_clock.sv | 117 +++++++++++
 tb/tb_multi_derived_clock.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_derived_clock.sv
// Multi-channel programmable clock/strobe generator: one shared prescaler tick drives
// per-channel period/high/phase counters; config is shadowed and only swapped at wraps or loads.
module multi_derived_clock #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRE_W-1:0]     prescale,
  input  logic [NCH-1:0]       enable,
  input  logic                 sync,
  input  logic [NCH*CNT_W-1:0] period,
  input  logic [NCH*CNT_W-1:0] high_time,
  input  logic [NCH*CNT_W-1:0] phase,
  output logic [NCH-1:0]       output_clk,
  output logic [NCH-1:0]       rise_strobe,
  output logic [NCH-1:0]       fall_strobe
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic             tick;

  // >= rather than == so that lowering prescale below the running count cannot stall us
  always_comb begin
    tick      = 1'b0;
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    if (sync) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q >= prescale) begin
      tick      = 1'b1;
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CNT_W-1:0] per_live;
    logic [CNT_W-1:0] high_live;
    logic [CNT_W-1:0] phase_live;
    logic [CNT_W-1:0] load_cnt;

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] per_sh_q,  per_sh_d;
    logic [CNT_W-1:0] high_sh_q, high_sh_d;
    logic             en_q;
    logic             out_q,     out_d;
    logic             rise_q,    fall_q;
    logic             load;
    logic [CNT_W:0]   nxt;

    assign per_live   = period[gi*CNT_W +: CNT_W];
    assign high_live  = high_time[gi*CNT_W +: CNT_W];
    assign phase_live = phase[gi*CNT_W +: CNT_W];
    assign load_cnt   = (phase_live < per_live) ? phase_live : '0;
    assign load       = enable[gi] & (sync | ~en_q);

    always_comb begin
      cnt_d     = cnt_q;
      per_sh_d  = per_sh_q;
      high_sh_d = high_sh_q;
      out_d     = out_q;
      nxt       = {1'b0, cnt_q} + (CNT_W+1)'(1);
      if (!enable[gi]) begin
        cnt_d = '0;
        out_d = 1'b0;
      end else if (load) begin
        per_sh_d  = per_live;
        high_sh_d = high_live;
        cnt_d     = load_cnt;
        out_d     = (per_live != '0) && (load_cnt < high_live);
      end else if (tick) begin
        // A zero shadow period wraps every tick, so live inputs keep being resampled
        if (nxt >= {1'b0, per_sh_q}) begin
          nxt       = '0;
          per_sh_d  = per_live;
          high_sh_d = high_live;
        end
        cnt_d = nxt[CNT_W-1:0];
        out_d = (per_sh_d != '0) && (nxt < {1'b0, high_sh_d});
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        per_sh_q  <= '0;
        high_sh_q <= '0;
        en_q      <= 1'b0;
        out_q     <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        per_sh_q  <= per_sh_d;
        high_sh_q <= high_sh_d;
        en_q      <= enable[gi];
        out_q     <= out_d;
        rise_q    <= out_d & ~out_q;
        fall_q    <= ~out_d & out_q;
      end
    end

    assign output_clk[gi]  = out_q;
    assign rise_strobe[gi] = rise_q;
    assign fall_strobe[gi] = fall_q;
  end

endmodule

// File: tb/tb_multi_derived_clock.sv
// Scoreboard bench for multi_derived_clock: directed scenarios push expected strobe
// events (cycle, edge kind); a negedge monitor pops and checks them as strobes appear.
module tb_multi_derived_clock;
  localparam int NCH   = 4;
  localparam int CNT_W = 32;
  localparam int PRE_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [PRE_W-1:0]     prescale = '0;
  logic [NCH-1:0]       enable = '0;
  logic                 sync = 1'b0;
  logic [NCH*CNT_W-1:0] period = '0;
  logic [NCH*CNT_W-1:0] high_time = '0;
  logic [NCH*CNT_W-1:0] phase = '0;
  logic [NCH-1:0]       output_clk;
  logic [NCH-1:0]       rise_strobe;
  logic [NCH-1:0]       fall_strobe;

  multi_derived_clock #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prescale    (prescale),
    .enable      (enable),
    .sync        (sync),
    .period      (period),
    .high_time   (high_time),
    .phase       (phase),
    .output_clk  (output_clk),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe)
  );

  always #5 clk = ~clk;

  // cyc == k at the negedge following the k-th rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;

  ev_t exp_q[NCH][$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic set_ch(input int ch, input int per, input int hi, input int ph);
    period[ch*CNT_W +: CNT_W]    = per;
    high_time[ch*CNT_W +: CNT_W] = hi;
    phase[ch*CNT_W +: CNT_W]     = ph;
  endtask

  task automatic expect_ev(input int ch, input int c, input bit r);
    ev_t e;
    e.cyc  = c;
    e.rise = r;
    exp_q[ch].push_back(e);
  endtask

  task automatic push_clock(input int ch, input int r0, input int hi, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      expect_ev(ch, r0 + k*per, 1'b1);
      expect_ev(ch, r0 + k*per + hi, 1'b0);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("check %s = %b ok (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Monitor: every strobe must match the head of that channel's expected queue
  always @(negedge clk) begin
    ev_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      while (exp_q[ch].size() > 0 && exp_q[ch][0].cyc < cyc) begin
        e = exp_q[ch].pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL ch%0d missed_strobe: no strobe at cycle %0d, required %s",
                 ch, e.cyc, e.rise ? "rise" : "fall");
      end
      if (rise_strobe[ch] || fall_strobe[ch]) begin
        n_cmp++;
        if (exp_q[ch].size() == 0 || exp_q[ch][0].cyc != cyc) begin
          n_bad++;
          $display("FAIL ch%0d unexpected_strobe: rise=%b fall=%b at cycle %0d, required none",
                   ch, rise_strobe[ch], fall_strobe[ch], cyc);
        end else begin
          e = exp_q[ch].pop_front();
          if (rise_strobe[ch] !== e.rise || fall_strobe[ch] !== !e.rise || output_clk[ch] !== e.rise) begin
            n_bad++;
            $display("FAIL ch%0d strobe_kind: rise=%b fall=%b clk=%b at cycle %0d, required %s",
                     ch, rise_strobe[ch], fall_strobe[ch], output_clk[ch], cyc, e.rise ? "rise" : "fall");
          end else begin
            $display("ch%0d %s strobe at cycle %0d ok", ch, e.rise ? "rise" : "fall", cyc);
          end
        end
      end
    end
  end

  // ch1 events after the quadrature sync, offsets from the sync edge, alternating rise/fall
  int ch1_offs[20] = '{0, 1, 3, 5, 7, 9, 11, 13, 14, 16, 17, 19, 21, 24, 26, 28, 30, 32, 34, 35};

  initial begin
    int b, s, e, x;

    // Reset state
    repeat (3) @(negedge clk);
    check_vec("reset_output_clk", output_clk, '0);
    check_vec("reset_rise", rise_strobe, '0);
    check_vec("reset_fall", fall_strobe, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide by 4, then disable while high
    set_ch(0, 4, 2, 0);
    prescale = 8'd0;
    enable   = 4'b0001;
    b = cyc + 1;
    push_clock(0, b, 2, 4, 3);
    expect_ev(0, b + 12, 1'b1);
    wait_until(b + 12);
    enable = 4'b0000;
    expect_ev(0, b + 13, 1'b0);
    wait_until(b + 14);
    check_vec("disable_output_clk", output_clk, '0);

    // Prescaled: enable rise and sync together give a single load
    set_ch(0, 3, 1, 0);
    prescale = 8'd2;
    enable   = 4'b0001;
    sync     = 1'b1;
    s = cyc + 1;
    push_clock(0, s, 3, 9, 3);
    @(negedge clk);
    sync = 1'b0;
    wait_until(s + 22);
    enable = 4'b0000;
    wait_until(s + 24);
    prescale = 8'd0;

    // Quadrature via phase, period change/restore on ch1, then re-sync
    set_ch(0, 4, 2, 0);
    set_ch(1, 4, 2, 1);
    enable = 4'b0011;
    sync   = 1'b1;
    s = cyc + 1;
    push_clock(0, s, 2, 4, 6);
    push_clock(0, s + 23, 2, 4, 3);
    for (int i = 0; i < 20; i++) expect_ev(1, s + ch1_offs[i], (i % 2) == 0);
    @(negedge clk);
    sync = 1'b0;
    wait_until(s + 7);
    set_ch(1, 3, 2, 1);
    wait_until(s + 15);
    set_ch(1, 4, 2, 1);
    wait_until(s + 22);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    wait_until(s + 34);
    enable = 4'b0000;
    wait_until(s + 36);

    // Glitch-free reconfig: 8/4 period completes, then 2/1
    set_ch(0, 8, 4, 0);
    enable = 4'b0001;
    e = cyc + 1;
    expect_ev(0, e, 1'b1);
    expect_ev(0, e + 4, 1'b0);
    push_clock(0, e + 8, 1, 2, 4);
    wait_until(e + 1);
    set_ch(0, 2, 1, 0);
    wait_until(e + 15);
    enable = 4'b0000;
    wait_until(e + 17);

    // Degenerate: high=0 on ch2, high==period on ch3
    set_ch(2, 4, 0, 0);
    set_ch(3, 5, 5, 0);
    enable = 4'b1100;
    e = cyc + 1;
    expect_ev(3, e, 1'b1);
    wait_until(e + 10);
    check_vec("degen_levels", output_clk, 4'b1000);

    // period=0 on ch2, then recovery without re-enable
    enable[2] = 1'b0;
    @(negedge clk);
    set_ch(2, 0, 2, 0);
    enable[2] = 1'b1;
    repeat (6) @(negedge clk);
    check_vec("period0_levels", output_clk, 4'b1000);
    set_ch(2, 4, 2, 0);
    x = cyc + 1;
    push_clock(2, x, 2, 4, 2);
    expect_ev(2, x + 8, 1'b1);
    wait_until(x + 8);
    check_vec("pre_reset_levels", output_clk, 4'b1100);

    // Reset while high, then fresh load on release
    rst_n = 1'b0;
    wait_until(x + 9);
    check_vec("midrun_reset_clk", output_clk, '0);
    check_vec("midrun_reset_rise", rise_strobe, '0);
    check_vec("midrun_reset_fall", fall_strobe, '0);
    rst_n = 1'b1;
    expect_ev(3, x + 10, 1'b1);
    push_clock(2, x + 10, 2, 4, 2);
    wait_until(x + 17);
    enable = 4'b0000;
    expect_ev(3, x + 18, 1'b0);
    wait_until(x + 20);
    check_vec("final_levels", output_clk, '0);

    for (int ch = 0; ch < NCH; ch++) begin
      check_int($sformatf("pending_ch%0d", ch), exp_q[ch].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
